// File: rtl/muldiv_seq.sv
// Iterative RV64M multiply/divide unit: shift-add multiply, restoring divide, valid/ready handshake.
// Define MULDIV_FAST_MUL_EN to complete multiplies in one cycle with a combinational multiplier.
module muldiv_seq #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic            is_w,
  input  logic [XLEN-1:0] value1,
  input  logic [XLEN-1:0] value2,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam int H  = XLEN / 2;
  localparam int CW = $clog2(XLEN + 1);
  localparam logic [H-1:0]    MIN_H = {1'b1, {(H-1){1'b0}}};
  localparam logic [XLEN-1:0] MIN_X = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e              state_q, state_d;
  logic [2:0]          op_q;
  logic                w_q, neg_q, remNeg_q;
  logic [2*XLEN-1:0]   acc_q, mcand_q;
  logic [XLEN-1:0]     opb_q, result_q;
  logic [CW-1:0]       cnt_q;

  logic                accept, wIn, sgn1, sgn2, s1, s2, divZero, ovf, direct;
  logic [XLEN-1:0]     aExt, bExt, mag1, mag2, directVal;
  logic [2*XLEN-1:0]   mulAcc, divAcc, accStep;
  logic [XLEN:0]       remSh, diff;
  logic [XLEN-1:0]     quo, rem, finRaw, finVal;
`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0]   fullProd;
`endif

  function automatic logic [XLEN-1:0] wfix(input logic w, input logic [XLEN-1:0] x);
    wfix = w ? {{H{x[H-1]}}, x[H-1:0]} : x;
  endfunction

  function automatic logic [XLEN-1:0] mulSel(input logic [2:0] o, input logic [2*XLEN-1:0] p);
    mulSel = (o[1:0] == 2'd0) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction

  assign accept = (state_q == IDLE) && in_valid && !kill;

  // Operands are narrowed for W ops, extended per signedness, then reduced to magnitudes.
  always_comb begin : decode
    wIn  = is_w && (op[2] || (op == 3'd0));
    sgn1 = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
    sgn2 = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
    aExt = wIn ? {{H{sgn1 & value1[H-1]}}, value1[H-1:0]} : value1;
    bExt = wIn ? {{H{sgn2 & value2[H-1]}}, value2[H-1:0]} : value2;
    s1   = sgn1 & aExt[XLEN-1];
    s2   = sgn2 & bExt[XLEN-1];
    mag1 = s1 ? -aExt : aExt;
    mag2 = s2 ? -bExt : bExt;
    divZero = op[2] && (bExt == '0);
    ovf = op[2] && !op[0] &&
          (wIn ? ((aExt[H-1:0] == MIN_H) && (bExt[H-1:0] == '1))
               : ((aExt == MIN_X) && (bExt == '1)));
    direct    = divZero || ovf;
    directVal = '0;
    if (divZero)  directVal = op[1] ? aExt : '1;
    else if (ovf) directVal = op[1] ? '0 : aExt;
`ifdef MULDIV_FAST_MUL_EN
    fullProd = {{XLEN{1'b0}}, mag1} * {{XLEN{1'b0}}, mag2};
    if (!op[2]) begin
      direct    = 1'b1;
      directVal = mulSel(op, (s1 ^ s2) ? -fullProd : fullProd);
    end
`endif
    directVal = wfix(wIn, directVal);
  end

  // One shift-add or restoring-divide step; quotient bits enter at the bottom of acc_q.
  always_comb begin : iterate
    mulAcc  = acc_q + (opb_q[0] ? mcand_q : '0);
    remSh   = acc_q[2*XLEN-1:XLEN-1];
    diff    = remSh - {1'b0, opb_q};
    divAcc  = {diff[XLEN] ? remSh[XLEN-1:0] : diff[XLEN-1:0], acc_q[XLEN-2:0], ~diff[XLEN]};
    accStep = op_q[2] ? divAcc : mulAcc;
    quo     = accStep[XLEN-1:0];
    rem     = accStep[2*XLEN-1:XLEN];
    if (op_q[2]) finRaw = op_q[1] ? (remNeg_q ? -rem : rem) : (neg_q ? -quo : quo);
    else         finRaw = mulSel(op_q, neg_q ? -accStep : accStep);
    finVal = wfix(w_q, finRaw);
  end

  always_ff @(posedge clk or negedge reset_n) begin : stateReg
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin : nextState
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = direct ? DONE : BUSY;
      BUSY: if (kill) state_d = IDLE; else if (cnt_q == CW'(1)) state_d = DONE;
      DONE: if (kill || out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin : fsmOutputs
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin : datapath
    if (!reset_n) begin
      op_q     <= '0;
      w_q      <= 1'b0;
      neg_q    <= 1'b0;
      remNeg_q <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      opb_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else if (accept) begin
      op_q     <= op;
      w_q      <= wIn;
      neg_q    <= s1 ^ s2;
      remNeg_q <= s1;
      // W divides pre-shift the dividend so only H iterations are needed.
      acc_q    <= op[2] ? {{XLEN{1'b0}}, (wIn ? (mag1 << H) : mag1)} : '0;
      mcand_q  <= {{XLEN{1'b0}}, mag1};
      opb_q    <= mag2;
      cnt_q    <= direct ? '0 : (wIn ? CW'(H) : CW'(XLEN));
      if (direct) result_q <= directVal;
    end else if ((state_q == BUSY) && !kill) begin
      acc_q   <= accStep;
      mcand_q <= mcand_q << 1;
      opb_q   <= op_q[2] ? opb_q : (opb_q >> 1);
      cnt_q   <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) result_q <= finVal;
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed cases plus random ops against an arithmetic reference model.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  op = 3'd0;
  logic        is_w = 1'b0;
  logic [63:0] value1 = '0;
  logic [63:0] value2 = '0;
  logic        kill = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] result;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  muldiv_seq #(.XLEN(64)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .is_w     (is_w),
    .value1   (value1),
    .value2   (value2),
    .kill     (kill),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic wordOp(input logic [2:0] o, input logic w);
    return w && (o == 3'd0 || o[2]);
  endfunction

  // RISC-V M-extension semantics written with plain SystemVerilog arithmetic.
  function automatic logic [63:0] refModel(input logic [2:0] o, input logic w,
                                           input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] sa, sb, ubs, p;
    logic [127:0]        ua, ub;
    longint              sl1, sl2;
    int                  sa32, sb32;
    int unsigned         ua32, ub32;
    logic [31:0]         r32;
    logic [63:0]         r;
    if (wordOp(o, w)) begin
      sa32 = a[31:0]; sb32 = b[31:0]; ua32 = a[31:0]; ub32 = b[31:0];
      case (o)
        3'd0: r32 = ua32 * ub32;
        3'd4: if (ub32 == 0) r32 = '1;
              else if (ua32 == 32'h8000_0000 && ub32 == 32'hffff_ffff) r32 = ua32;
              else r32 = sa32 / sb32;
        3'd5: r32 = (ub32 == 0) ? '1 : ua32 / ub32;
        3'd6: if (ub32 == 0) r32 = ua32;
              else if (ua32 == 32'h8000_0000 && ub32 == 32'hffff_ffff) r32 = '0;
              else r32 = sa32 % sb32;
        default: r32 = (ub32 == 0) ? ua32 : ua32 % ub32;
      endcase
      return {{32{r32[31]}}, r32};
    end
    sa = $signed(a); sb = $signed(b); ubs = {64'b0, b};
    ua = {64'b0, a}; ub = {64'b0, b};
    sl1 = a; sl2 = b;
    case (o)
      3'd0: r = a * b;
      3'd1: begin p = sa * sb;  r = p[127:64]; end
      3'd2: begin p = sa * ubs; r = p[127:64]; end
      3'd3: begin p = ua * ub;  r = p[127:64]; end
      3'd4: if (b == 0) r = '1;
            else if (a == 64'h8000_0000_0000_0000 && b == '1) r = a;
            else r = sl1 / sl2;
      3'd5: r = (b == 0) ? '1 : a / b;
      3'd6: if (b == 0) r = a;
            else if (a == 64'h8000_0000_0000_0000 && b == '1) r = '0;
            else r = sl1 % sl2;
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int expLat(input logic [2:0] o, input logic w,
                                input logic [63:0] a, input logic [63:0] b);
    logic we, zero, ovfl;
    we   = wordOp(o, w);
    zero = we ? (b[31:0] == 0) : (b == 0);
    ovfl = !o[0] && (we ? (a[31:0] == 32'h8000_0000 && b[31:0] == '1)
                        : (a == 64'h8000_0000_0000_0000 && b == '1));
    if (o[2] && (zero || ovfl)) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!o[2]) return 1;
`endif
    return we ? 33 : 65;
  endfunction

  // One full transaction; hold > 0 keeps out_ready low for that many cycles after out_valid.
  task automatic applyStimulus(input string tag, input logic [2:0] o, input logic w,
                               input logic [63:0] a, input logic [63:0] b,
                               input logic [63:0] exp, input int hold);
    int lat;
    int expL;
    expL = expLat(o, w, a, b);
    @(negedge clk);
    checkOutput({tag, "_in_ready"}, in_ready, 1);
    op = o; is_w = w; value1 = a; value2 = b;
    in_valid = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op = 3'($urandom_range(0, 7));
    value1 = {$urandom, $urandom};
    value2 = {$urandom, $urandom};
    lat = 1;
    while (!out_valid && lat <= 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput({tag, "_latency"}, 64'(lat), 64'(expL));
    checkOutput({tag, "_result"}, result, exp);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      #1;
      checkOutput({tag, "_hold_result"}, result, exp);
      checkOutput({tag, "_hold_in_ready"}, in_ready, 0);
      checkOutput({tag, "_hold_out_valid"}, out_valid, 1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput({tag, "_drain_out_valid"}, out_valid, 0);
    checkOutput({tag, "_drain_in_ready"}, in_ready, 1);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [2:0]  o;
    logic        w;
    logic [63:0] a, b;

    #3;
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_result", result, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("reset_in_ready", in_ready, 1);

    applyStimulus("mulhu_max", 3'd3, 1'b0, '1, '1, 64'hffff_ffff_ffff_fffe, 0);
    applyStimulus("mulw", 3'd0, 1'b1, 64'h7fff_ffff, 64'd2, 64'hffff_ffff_ffff_fffe, 0);
    applyStimulus("div_neg", 3'd4, 1'b0, -64'sd7, 64'd2, 64'hffff_ffff_ffff_fffd, 0);
    applyStimulus("rem_neg", 3'd6, 1'b0, -64'sd7, 64'd2, 64'hffff_ffff_ffff_ffff, 0);
    applyStimulus("divu_zero", 3'd5, 1'b0, 64'd5, 64'd0, 64'hffff_ffff_ffff_ffff, 0);
    applyStimulus("remu_zero", 3'd7, 1'b0, 64'd5, 64'd0, 64'd5, 0);
    applyStimulus("divw_ovf", 3'd4, 1'b1, 64'h8000_0000, 64'hffff_ffff, 64'hffff_ffff_8000_0000, 0);
    applyStimulus("remw_ovf", 3'd6, 1'b1, 64'h8000_0000, 64'hffff_ffff, 64'd0, 0);
    applyStimulus("div_ovf_hold", 3'd4, 1'b0, 64'h8000_0000_0000_0000, '1,
                  64'h8000_0000_0000_0000, 10);

    // Kill in the 20th cycle of a divide.
    @(negedge clk);
    op = 3'd4; is_w = 1'b0; value1 = 64'd1000; value2 = 64'd7; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (19) @(posedge clk);
    @(negedge clk);
    kill = 1'b1;
    @(posedge clk);
    #1 kill = 1'b0;
    checkOutput("kill_busy_out_valid", out_valid, 0);
    checkOutput("kill_busy_in_ready", in_ready, 1);
    applyStimulus("mul_after_kill", 3'd0, 1'b0, 64'd3, 64'd4, 64'd12, 0);

    // A request offered together with kill must be dropped.
    @(negedge clk);
    kill = 1'b1; in_valid = 1'b1; op = 3'd5; value1 = 64'd5; value2 = 64'd0;
    @(posedge clk);
    #1 kill = 1'b0; in_valid = 1'b0;
    checkOutput("kill_accept_in_ready", in_ready, 1);
    checkOutput("kill_accept_out_valid", out_valid, 0);

    // Kill while a result waits in DONE.
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; op = 3'd5; value1 = 64'd5; value2 = 64'd0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    checkOutput("kill_done_pre_valid", out_valid, 1);
    @(negedge clk);
    kill = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 kill = 1'b0;
    checkOutput("kill_done_out_valid", out_valid, 0);
    checkOutput("kill_done_in_ready", in_ready, 1);

    // Asynchronous reset in the middle of an iterative divide.
    @(negedge clk);
    op = 3'd5; is_w = 1'b0; value1 = 64'd12345; value2 = 64'd11; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async_reset_out_valid", out_valid, 0);
    checkOutput("async_reset_result", result, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("after_reset_in_ready", in_ready, 1);
    applyStimulus("divu_after_reset", 3'd5, 1'b0, 64'd100, 64'd7, 64'd14, 0);

    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      w = 1'($urandom_range(0, 1));
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: b = '0;
        1: begin a = 64'h8000_0000_0000_0000; b = '1; end
        2: begin a = {$urandom, 32'h8000_0000}; b = {$urandom, 32'hffff_ffff}; end
        3: b = 64'($urandom_range(1, 20));
        default: ;
      endcase
      applyStimulus($sformatf("rnd%0d_op%0d_w%0d", i, o, w), o, w, a, b, refModel(o, w, a, b), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
